// File: rtl/shift_sequencer.sv
// shift_sequencer
// Control sequencer for an external load/shift datapath register. A command
// (data, shift count, fill mode) is captured in IDLE. The sequencer then
// spends one cycle loading the value, issues exactly 'amount' shift cycles
// (pausable with hold, cancellable with abort), and ends with a one-cycle
// done pulse.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      command request, accepted only in IDLE when abort is low
//   data_in    value captured into load_val on command acceptance
//   amount     number of shift cycles to issue
//   arith      1 = arithmetic (sign fill), 0 = logical (zero fill)
//   hold       pauses shifting while high
//   abort      cancels the active command
//   load_n     datapath load enable, active-low
//   shift      datapath shift enable
//   asr        datapath arithmetic-fill select
//   load_val   captured data value driven to the datapath
//   busy       high in any state other than IDLE
//   done       one-cycle completion pulse
//   remaining  shift cycles still to issue
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    amount,
  input  logic             arith,
  input  logic             hold,
  input  logic             abort,
  output logic             load_n,
  output logic             shift,
  output logic             asr,
  output logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] load_val_r, load_val_s;
  logic [CW-1:0]    remaining_r, remaining_s;
  logic             mode_r, mode_s;
  // shift_r marks the current SHIFT cycle as an issuing cycle. Hold is
  // sampled at the edge that enters a cycle, so the shift enable comes
  // straight from a flop and no input reaches an output combinationally.
  logic             shift_r, shift_s;

  // State and captured-command registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      load_val_r  <= VAL_ZERO;
      remaining_r <= CNT_ZERO;
      mode_r      <= 1'b0;
      shift_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      load_val_r  <= load_val_s;
      remaining_r <= remaining_s;
      mode_r      <= mode_s;
      shift_r     <= shift_s;
    end
  end

  // Next-state, capture and count logic.
  always_comb begin
    state_s     = state_r;
    load_val_s  = load_val_r;
    remaining_s = remaining_r;
    mode_s      = mode_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s     = LOAD;
          load_val_s  = data_in;
          remaining_s = amount;
          mode_s      = arith;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_s     = IDLE;
          remaining_s = CNT_ZERO;
        end else if (remaining_r == CNT_ZERO) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_s     = IDLE;
          remaining_s = CNT_ZERO;
        end else begin
          // Count only cycles that actually issued a shift; never wrap.
          if (shift_r && (remaining_r != CNT_ZERO)) begin
            remaining_s = remaining_r - CNT_ONE;
          end else begin
            remaining_s = remaining_r;
          end
          if ((remaining_r == CNT_ZERO) || (shift_r && (remaining_r == CNT_ONE))) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end
      end
      DONE: begin
        state_s     = IDLE;
        remaining_s = CNT_ZERO;
      end
      default: begin
        state_s     = IDLE;
        remaining_s = CNT_ZERO;
      end
    endcase
    // The next cycle issues a shift only if it is a SHIFT cycle and hold is low.
    shift_s = (state_s == SHIFT) && !hold;
  end

  // Moore output decode from registered state.
  always_comb begin
    load_n    = (state_r != LOAD);
    shift     = shift_r && (state_r == SHIFT);
    asr       = (state_r == SHIFT) && mode_r;
    load_val  = load_val_r;
    busy      = (state_r != IDLE);
    done      = (state_r == DONE);
    remaining = remaining_r;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected command
// results and per-shift remaining values; a negedge monitor pops and
// compares them whenever the DUT loads, shifts or signals done.
module tb_shift_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] amount;
  logic       arith;
  logic       hold;
  logic       abort;
  logic       load_n;
  logic       shift;
  logic       asr;
  logic [7:0] load_val;
  logic       busy;
  logic       done;
  logic [3:0] remaining;

  shift_sequencer #(.WIDTH(8), .CW(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .data_in  (data_in),
    .amount   (amount),
    .arith    (arith),
    .hold     (hold),
    .abort    (abort),
    .load_n   (load_n),
    .shift    (shift),
    .asr      (asr),
    .load_val (load_val),
    .busy     (busy),
    .done     (done),
    .remaining(remaining)
  );

  typedef struct {
    logic [7:0] lv;
    int         shifts;
    logic       asr_seen;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] rem_q[$];

  int total = 0;
  int bad   = 0;

  int         m_shifts = 0;
  int         m_cyc    = 0;
  logic       m_asr    = 1'b0;
  logic [7:0] m_lv     = 8'h00;
  exp_t       m_e;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: track each command from its load cycle and compare on shift/done.
  always @(negedge clock) begin
    if (reset_n) begin
      if (!load_n) begin
        m_lv     = load_val;
        m_shifts = 0;
        m_asr    = 1'b0;
        m_cyc    = 0;
        chk("load_shift_low", {31'd0, shift}, 32'd0);
        chk("load_asr_low", {31'd0, asr}, 32'd0);
      end else if (busy) begin
        m_cyc++;
        if (shift) begin
          m_shifts++;
          m_asr = m_asr | asr;
          if (rem_q.size() == 0) chk("shift_unexpected", {31'd0, shift}, 32'd0);
          else chk("rem_on_shift", {28'd0, remaining}, {28'd0, rem_q.pop_front()});
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("cmd_load_val", {24'd0, m_lv}, {24'd0, m_e.lv});
          chk("cmd_shift_count", m_shifts, m_e.shifts);
          chk("cmd_asr", {31'd0, m_asr}, {31'd0, m_e.asr_seen});
          chk("cmd_latency", m_cyc, m_e.lat);
          chk("done_remaining", {28'd0, remaining}, 32'd0);
          chk("done_shift_low", {31'd0, shift}, 32'd0);
          chk("done_asr_low", {31'd0, asr}, 32'd0);
          chk("done_load_n_high", {31'd0, load_n}, 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] d, input logic [3:0] a, input logic ar);
    start   = 1'b1;
    data_in = d;
    amount  = a;
    arith   = ar;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_load_n"}, {31'd0, load_n}, 32'd1);
    chk({nm, "_shift"}, {31'd0, shift}, 32'd0);
    chk({nm, "_asr"}, {31'd0, asr}, 32'd0);
    chk({nm, "_load_val"}, {24'd0, load_val}, 32'd0);
    chk({nm, "_remaining"}, {28'd0, remaining}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    data_in = 8'h00;
    amount  = 4'd0;
    arith   = 1'b0;
    hold    = 1'b0;
    abort   = 1'b0;
    #2;
    chk_reset_vals("por");

    // Basic arithmetic command, accepted on the first edge after reset release.
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back('{8'hB4, 3, 1'b1, 4});
    rem_q.push_back(4'd3); rem_q.push_back(4'd2); rem_q.push_back(4'd1);
    issue(8'hB4, 4'd3, 1'b1);
    chk("a_load_n", {31'd0, load_n}, 32'd0);
    chk("a_load_val", {24'd0, load_val}, 32'h0000_00B4);
    chk("a_load_rem", {28'd0, remaining}, 32'd3);
    wait_idle("a_idle");
    chk("a_busy_after", {31'd0, busy}, 32'd0);

    // Zero-length command: LOAD then DONE.
    exp_q.push_back('{8'h5A, 0, 1'b0, 1});
    issue(8'h5A, 4'd0, 1'b0);
    @(negedge clock);
    chk("b_done_two_after", {31'd0, done}, 32'd1);
    wait_idle("b_idle");

    // Hold on the 2nd and 3rd shift cycles.
    exp_q.push_back('{8'h3C, 4, 1'b0, 7});
    rem_q.push_back(4'd4); rem_q.push_back(4'd3); rem_q.push_back(4'd2); rem_q.push_back(4'd1);
    issue(8'h3C, 4'd4, 1'b0);
    @(negedge clock);
    chk("c_s1_shift", {31'd0, shift}, 32'd1);
    hold = 1'b1;
    @(negedge clock);
    chk("c_s2_shift", {31'd0, shift}, 32'd0);
    chk("c_s2_rem", {28'd0, remaining}, 32'd3);
    chk("c_s2_asr", {31'd0, asr}, 32'd0);
    @(negedge clock);
    chk("c_s3_shift", {31'd0, shift}, 32'd0);
    chk("c_s3_rem", {28'd0, remaining}, 32'd3);
    chk("c_s3_busy", {31'd0, busy}, 32'd1);
    hold = 1'b0;
    wait_idle("c_idle");

    // Abort on the 2nd shift cycle.
    rem_q.push_back(4'd5); rem_q.push_back(4'd4);
    issue(8'hC3, 4'd5, 1'b1);
    @(negedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("d_abort_busy", {31'd0, busy}, 32'd0);
    chk("d_abort_rem", {28'd0, remaining}, 32'd0);
    chk("d_abort_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    chk("d_no_done", {31'd0, done}, 32'd0);
    // start together with abort in IDLE is not accepted.
    start   = 1'b1;
    abort   = 1'b1;
    data_in = 8'hEE;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    chk("d_idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("d_idle_abort_val", {24'd0, load_val}, 32'h0000_00C3);
    @(negedge clock);
    exp_q.push_back('{8'h81, 1, 1'b1, 2});
    rem_q.push_back(4'd1);
    issue(8'h81, 4'd1, 1'b1);
    wait_idle("d_idle");

    // Asynchronous reset between edges during SHIFT.
    rem_q.push_back(4'd6); rem_q.push_back(4'd5);
    issue(8'hFF, 4'd6, 1'b1);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("e_no_done_after_reset", {31'd0, done}, 32'd0);
    end

    // start held high through LOAD and DONE: second accept only in IDLE.
    exp_q.push_back('{8'h11, 0, 1'b0, 1});
    exp_q.push_back('{8'h22, 0, 1'b0, 1});
    start   = 1'b1;
    data_in = 8'h11;
    amount  = 4'd0;
    arith   = 1'b0;
    @(negedge clock);
    data_in = 8'h22;
    @(negedge clock);
    chk("f_done", {31'd0, done}, 32'd1);
    chk("f_val_stable", {24'd0, load_val}, 32'h0000_0011);
    @(negedge clock);
    chk("f_idle_after_done", {31'd0, busy}, 32'd0);
    @(negedge clock);
    start = 1'b0;
    chk("f_second_load", {31'd0, load_n}, 32'd0);
    chk("f_second_val", {24'd0, load_val}, 32'h0000_0022);
    wait_idle("f_idle");

    repeat (3) @(negedge clock);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("rem_q_drained", rem_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
